ifu_prefetch_queue: RTL and testbench
=====================================

// Module: ifu_prefetch_queue
// PURPOSE
//  Parametrised next-generation fetch front-end for Core101: PC generator, single-outstanding memory
//  read handshake and QDEPTH-entry instruction queue feeding the decode stage via valid/ready.
//  Supports halt and redirect (branch/jump flush); sits between main memory and DECODE_UNIT.
// PARAMETERS
//  XLEN      32         address/instruction width
//  QDEPTH    4          queue entries; power of two, >=2
//  RESET_PC  32'h0      fetch address after reset
//  PC_STEP   4          byte increment per fetched instruction
// PORTS
//  clock_in            in   1     core clock
//  reset_in            in   1     asynchronous, active-high reset
//  halt_in             in   1     blocks issue of new memory reads
//  redirect_valid_in   in   1     flush queue, restart fetch at redirect_addr_in
//  redirect_addr_in    in   XLEN  new fetch address; bits[1:0] forced to 0
//  mem_read_out        out  1     read request, held high until mem_valid_in
//  mem_addr_out        out  XLEN  read address, stable while mem_read_out=1
//  mem_data_in         in   XLEN  read data, sampled when mem_valid_in=1
//  mem_valid_in        in   1     read response; ignored when mem_read_out=0
//  dec_valid_out       out  1     queue head valid (count!=0)
//  dec_ready_in        in   1     decode accepts head; pop when valid&ready
//  dec_ins_out         out  XLEN  head instruction
//  dec_pc_out          out  XLEN  head instruction address
//  queue_count_out     out  $clog2(QDEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, count=0, rd/wr ptr=0, state=S_FETCH, mem_read_out=0, dec_valid_out=0,
//   dec_ins_out/dec_pc_out=0; reset mid-transaction abandons the outstanding read.
//  FSM S_FETCH: if !halt_in & !redirect & count<QDEPTH -> S_WAIT (mem_read_out=1, mem_addr_out=fetch_pc).
//  S_WAIT on mem_valid_in: push {fetch_pc,mem_data_in}, fetch_pc+=PC_STEP (wraps mod 2^XLEN);
//   stay S_WAIT with next address if !halt_in & free slot remains after push/pop, else S_FETCH.
//  Min latency: request cycle N, response N, entry visible at dec_valid_out N+1; back-to-back 1 ins/cycle.
//  Redirect (highest priority): count<=0, ptrs<=0, fetch_pc<=redirect_addr_in&~3. In S_WAIT without
//   same-cycle mem_valid_in -> S_DISCARD (keep old request up, drop its data, then S_FETCH);
//   with same-cycle mem_valid_in -> data dropped, S_FETCH. Same-cycle pop counts as accepted by decode.
//   Redirect in S_DISCARD updates fetch_pc only.
//  Full: no request issued while count==QDEPTH; simultaneous push+pop when full is legal (count unchanged).
//  Empty: dec_valid_out=0, dec_ins_out/dec_pc_out hold last head value, pop ignored.
//  Pointers wrap modulo QDEPTH; count never exceeds QDEPTH (assertion).
//  Halt: only gates new requests; outstanding read completes and is pushed; queue drains normally.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds perf_fetch_count_out[31:0] (pushes, wraps) and perf_stall_count_out[31:0]
//   (cycles in S_WAIT/S_DISCARD with mem_valid_in=0, wraps); both reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  core101_fetch_pkg: XLEN default, fetch state encoding (S_FETCH/S_WAIT/S_DISCARD),
//   queue entry struct {pc,ins}, PC_STEP constant.
//  Sub-module ifu_fetch_fifo: circular buffer with push/pop/flush, count, head outputs.
// TESTING
//  Reset, mem_valid_in=1 each cycle, ready=1 -> addrs 0,4,8,..; dec_pc_out follows one cycle behind.
//  ready=0, QDEPTH=4 -> exactly 4 pushes, mem_read_out=0, queue_count_out=4; ready=1 -> drains in order.
//  Redirect to 0x103 while request outstanding, valid 3 cycles later -> data dropped, next addr 0x100.
//  Redirect coincident with mem_valid_in -> count=0, no push, next request addr=redirect addr.
//  halt_in=1 mid-WAIT -> current read completes and queues, no further mem_read_out until halt_in=0.
//  FETCH_PERF_EN: 5 responses with 2 wait cycles each -> perf_fetch=5, perf_stall=10.

Source files
------------

// File: rtl/core101_fetch_pkg.sv
// Shared definitions for the Core101 fetch front-end: default widths, fetch FSM
// state encoding and the instruction queue entry layout.
package core101_fetch_pkg;

   localparam int unsigned XLEN_DEF    = 32;
   localparam int unsigned PC_STEP_DEF = 4;

   localparam logic [1:0] S_FETCH   = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] ins;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Circular instruction queue for the fetch front-end: push/pop/flush, occupancy
// count and head outputs that hold the last head value while empty.
module ifu_fetch_fifo
   import core101_fetch_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned QDEPTH = 4,
   localparam int unsigned PW    = $clog2(QDEPTH),
   localparam int unsigned CW    = PW + 1
) (
   input  logic            clock_in,
   input  logic            reset_in,
   input  logic            flush,
   input  logic            push,
   input  logic [XLEN-1:0] push_pc,
   input  logic [XLEN-1:0] push_ins,
   input  logic            pop,
   output logic [CW-1:0]   count,
   output logic            head_valid,
   output logic [XLEN-1:0] head_pc,
   output logic [XLEN-1:0] head_ins
);

   logic [XLEN-1:0] pc_mem  [QDEPTH];
   logic [XLEN-1:0] ins_mem [QDEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [XLEN-1:0] last_pc;
   logic [XLEN-1:0] last_ins;
   logic            do_push;
   logic            do_pop;

   assign head_valid = (count != '0);
   assign do_pop     = pop & head_valid & ~flush;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_push    = push & ~flush & ((count < CW'(QDEPTH)) | do_pop);

   assign head_pc  = head_valid ? pc_mem[rd_ptr]  : last_pc;
   assign head_ins = head_valid ? ins_mem[rd_ptr] : last_ins;

   always_ff @(posedge clock_in) begin
      if (do_push) begin
         pc_mem[wr_ptr]  <= push_pc;
         ins_mem[wr_ptr] <= push_ins;
      end
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         last_pc  <= '0;
         last_ins <= '0;
      end else begin
         if (head_valid) begin
            last_pc  <= pc_mem[rd_ptr];
            last_ins <= ins_mem[rd_ptr];
         end
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
         end
      end
   end

   count_in_range : assert property (@(posedge clock_in) disable iff (reset_in)
      count <= CW'(QDEPTH));

endmodule

// File: rtl/ifu_prefetch_queue.sv
// Core101 fetch front-end: PC generator, single-outstanding memory read and
// instruction queue toward decode. FETCH_PERF_EN adds fetch/stall perf counters.
//
// state     | meaning
// S_FETCH   | no read outstanding; issue one when not halted and a slot is free
// S_WAIT    | read outstanding; response is pushed into the queue
// S_DISCARD | read outstanding across a redirect; response is dropped
module ifu_prefetch_queue
   import core101_fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter int unsigned     QDEPTH   = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     PC_STEP  = PC_STEP_DEF,
   localparam int unsigned    CW       = $clog2(QDEPTH) + 1
) (
   input  logic            clock_in,
   input  logic            reset_in,
   input  logic            halt_in,
   input  logic            redirect_valid_in,
   input  logic [XLEN-1:0] redirect_addr_in,
   output logic            mem_read_out,
   output logic [XLEN-1:0] mem_addr_out,
   input  logic [XLEN-1:0] mem_data_in,
   input  logic            mem_valid_in,
   output logic            dec_valid_out,
   input  logic            dec_ready_in,
   output logic [XLEN-1:0] dec_ins_out,
   output logic [XLEN-1:0] dec_pc_out,
   output logic [CW-1:0]   queue_count_out
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetch_count_out,
   output logic [31:0]     perf_stall_count_out
`endif
);

   logic [1:0]      state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_pc;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] redirect_pc;
   logic            push;
   logic            pop_fire;
   logic [CW-1:0]   count_after;

   assign mem_read_out = (state == S_WAIT) || (state == S_DISCARD);
   // Held separately from fetch_pc so a discarded read keeps its address stable.
   assign mem_addr_out = req_pc;
   assign next_pc      = fetch_pc + XLEN'(PC_STEP);
   assign redirect_pc  = {redirect_addr_in[XLEN-1:2], 2'b00};
   assign push         = (state == S_WAIT) & mem_valid_in & ~redirect_valid_in;
   assign pop_fire     = dec_valid_out & dec_ready_in;
   assign count_after  = queue_count_out + CW'(push) - CW'(pop_fire);

   ifu_fetch_fifo #(
      .XLEN   (XLEN),
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clock_in   (clock_in),
      .reset_in   (reset_in),
      .flush      (redirect_valid_in),
      .push       (push),
      .push_pc    (req_pc),
      .push_ins   (mem_data_in),
      .pop        (pop_fire),
      .count      (queue_count_out),
      .head_valid (dec_valid_out),
      .head_pc    (dec_pc_out),
      .head_ins   (dec_ins_out)
   );

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state    <= S_FETCH;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
      end else begin
         case (state)
            S_FETCH: begin
               if (redirect_valid_in) begin
                  fetch_pc <= redirect_pc;
               end else if (!halt_in && (queue_count_out < CW'(QDEPTH))) begin
                  state  <= S_WAIT;
                  req_pc <= fetch_pc;
               end
            end
            S_WAIT: begin
               if (redirect_valid_in) begin
                  fetch_pc <= redirect_pc;
                  state    <= mem_valid_in ? S_FETCH : S_DISCARD;
               end else if (mem_valid_in) begin
                  fetch_pc <= next_pc;
                  req_pc   <= next_pc;
                  if (halt_in || (count_after >= CW'(QDEPTH))) state <= S_FETCH;
               end
            end
            S_DISCARD: begin
               if (redirect_valid_in) fetch_pc <= redirect_pc;
               if (mem_valid_in)      state    <= S_FETCH;
            end
            default: state <= S_FETCH;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         perf_fetch_count_out <= '0;
         perf_stall_count_out <= '0;
      end else begin
         if (push)                          perf_fetch_count_out <= perf_fetch_count_out + 32'd1;
         if (mem_read_out && !mem_valid_in) perf_stall_count_out <= perf_stall_count_out + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Bench for ifu_prefetch_queue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model of the fetch unit.
`timescale 1ns/1ps
module tb_ifu_prefetch_queue;
   import core101_fetch_pkg::*;

   localparam int QD = 4;

   logic        clock_in = 1'b0;
   logic        reset_in;
   logic        halt_in;
   logic        redirect_valid_in;
   logic [31:0] redirect_addr_in;
   logic        mem_read_out;
   logic [31:0] mem_addr_out;
   logic [31:0] mem_data_in;
   logic        mem_valid_in;
   logic        dec_valid_out;
   logic        dec_ready_in;
   logic [31:0] dec_ins_out;
   logic [31:0] dec_pc_out;
   logic [2:0]  queue_count_out;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_count_out;
   logic [31:0] perf_stall_count_out;
`endif

   ifu_prefetch_queue #(.XLEN(32), .QDEPTH(QD)) dut (
      .clock_in          (clock_in),
      .reset_in          (reset_in),
      .halt_in           (halt_in),
      .redirect_valid_in (redirect_valid_in),
      .redirect_addr_in  (redirect_addr_in),
      .mem_read_out      (mem_read_out),
      .mem_addr_out      (mem_addr_out),
      .mem_data_in       (mem_data_in),
      .mem_valid_in      (mem_valid_in),
      .dec_valid_out     (dec_valid_out),
      .dec_ready_in      (dec_ready_in),
      .dec_ins_out       (dec_ins_out),
      .dec_pc_out        (dec_pc_out),
      .queue_count_out   (queue_count_out)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_count_out (perf_fetch_count_out),
      .perf_stall_count_out (perf_stall_count_out)
`endif
   );

   always #5 clock_in = ~clock_in;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: expected request line, outstanding address, next fetch
   // address, discard flag and the ordered list of queued entries.
   fetch_entry_t m_q[$];
   logic         m_read;
   logic         m_disc;
   logic [31:0]  m_addr;
   logic [31:0]  m_pc;
   logic [31:0]  m_last_pc;
   logic [31:0]  m_last_ins;
`ifdef FETCH_PERF_EN
   int unsigned  m_fetch;
   int unsigned  m_stall;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_read     = 1'b0;
      m_disc     = 1'b0;
      m_addr     = '0;
      m_pc       = '0;
      m_last_pc  = '0;
      m_last_ins = '0;
`ifdef FETCH_PERF_EN
      m_fetch = 0;
      m_stall = 0;
`endif
   endtask

   task automatic do_reset();
      @(negedge clock_in);
      reset_in          = 1'b1;
      halt_in           = 1'b1;
      redirect_valid_in = 1'b0;
      redirect_addr_in  = '0;
      dec_ready_in      = 1'b0;
      mem_valid_in      = 1'b0;
      mem_data_in       = '0;
      model_reset();
      @(negedge clock_in);
      reset_in = 1'b0;
   endtask

   // One clock: compare DUT against the model, drive inputs, advance the model.
   task automatic step(input logic h, input logic r, input logic [31:0] ra,
                       input logic rdy, input logic v);
      int           qs;
      logic         pop;
      logic         resp;
      fetch_entry_t e;
      @(negedge clock_in);
      chk("mem_read", mem_read_out, m_read);
      if (m_read) chk("mem_addr", mem_addr_out, m_addr);
      chk("dec_valid", dec_valid_out, m_q.size() != 0);
      chk("count", queue_count_out, m_q.size());
      if (m_q.size() != 0) begin
         m_last_pc  = m_q[0].pc;
         m_last_ins = m_q[0].ins;
      end
      chk("dec_pc", dec_pc_out, m_last_pc);
      chk("dec_ins", dec_ins_out, m_last_ins);
`ifdef FETCH_PERF_EN
      chk("perf_fetch", perf_fetch_count_out, m_fetch);
      chk("perf_stall", perf_stall_count_out, m_stall);
`endif
      halt_in           = h;
      redirect_valid_in = r;
      redirect_addr_in  = ra;
      dec_ready_in      = rdy;
      mem_valid_in      = v;
      mem_data_in       = $urandom();

      qs   = m_q.size();
      pop  = (qs != 0) && rdy;
      resp = m_read && v;
`ifdef FETCH_PERF_EN
      if (m_read && !v) m_stall++;
`endif
      if (r) begin
         m_q.delete();
         m_pc = {ra[31:2], 2'b00};
         if (m_read && !v) m_disc = 1'b1;
         else begin
            m_read = 1'b0;
            m_disc = 1'b0;
         end
      end else begin
         if (pop) void'(m_q.pop_front());
         if (resp && m_disc) begin
            m_disc = 1'b0;
            m_read = 1'b0;
         end else if (resp) begin
            e.pc  = m_addr;
            e.ins = mem_data_in;
            m_q.push_back(e);
`ifdef FETCH_PERF_EN
            m_fetch++;
`endif
            m_pc = m_pc + 32'd4;
            if (!h && m_q.size() < QD) begin
               m_read = 1'b1;
               m_addr = m_pc;
            end else m_read = 1'b0;
         end else if (!m_read && !h && qs < QD) begin
            m_read = 1'b1;
            m_addr = m_pc;
         end
      end
   endtask

   initial begin
      int ph, pr, pv;
      do_reset();
      chk("rst_read", mem_read_out, 1'b0);
      chk("rst_valid", dec_valid_out, 1'b0);
      chk("rst_count", queue_count_out, 3'd0);
      chk("rst_pc", dec_pc_out, 32'd0);
      chk("rst_ins", dec_ins_out, 32'd0);

      // streaming, one instruction per cycle
      repeat (12) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      // decode stalled: queue fills and requests stop
      repeat (10) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("full_count", queue_count_out, 3'd4);
      chk("full_noreq", mem_read_out, 1'b0);
      // drain in order, memory silent so a new read stays outstanding
      repeat (6) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("drain_count", queue_count_out, 3'd0);

      // redirect with read outstanding, response arrives later and is dropped
      step(1'b0, 1'b1, 32'h103, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("redir_read", mem_read_out, 1'b1);
      chk("redir_addr", mem_addr_out, 32'h100);
      chk("redir_count", queue_count_out, 3'd0);

      // redirect coincident with a response
      repeat (2) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("coinc_count", queue_count_out, 3'd0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("coinc_addr", mem_addr_out, 32'h200);

      // halt mid-read: the read completes and queues, no further requests
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      repeat (4) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      chk("halt_noreq", mem_read_out, 1'b0);
      chk("halt_count", queue_count_out, 3'd1);
      chk("halt_pc", dec_pc_out, 32'h200);
      repeat (4) step(1'b0, 1'b0, '0, 1'b1, 1'b1);

      // randomized traffic with varying pressure
      for (int blk = 0; blk < 6; blk++) begin
         ph = $urandom_range(40);
         pr = $urandom_range(100, 20);
         pv = $urandom_range(100, 20);
         for (int i = 0; i < 500; i++)
            step($urandom_range(99) < ph, $urandom_range(99) < 4, $urandom(),
                 $urandom_range(99) < pr, $urandom_range(99) < pv);
      end

      // reset while a read is outstanding
      for (int i = 0; i < 20 && !m_read; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("mid_rst_setup", mem_read_out, 1'b1);
      do_reset();
      chk("mid_rst_read", mem_read_out, 1'b0);
      chk("mid_rst_count", queue_count_out, 3'd0);
      for (int i = 0; i < 200; i++)
         step(1'b0, $urandom_range(99) < 3, $urandom(), $urandom_range(1), $urandom_range(1));

`ifdef FETCH_PERF_EN
      do_reset();
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         repeat (2) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
         step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      end
      step(1'b1, 1'b0, '0, 1'b1, 1'b0);
      chk("perf_fetch5", perf_fetch_count_out, 32'd5);
      chk("perf_stall10", perf_stall_count_out, 32'd10);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
